muldiv_unit: RTL and testbench

Iterative RV32M/RV64M multiply/divide execution unit with parametrised XLEN, for the multi-cycle datapath. It runs alongside the ALU and is selected when the main decoder flags an M-extension instruction (opcode OP, funct7=0000001). The unit decodes funct3 internally and uses a valid/ready handshake on both input and output so the core can stall around it.

---
 rtl/muldiv_unit.sv | 207 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit.
//
// Multiply is shift-add on operand magnitudes into a 2*XLEN product,
// divide is restoring division; both take XLEN iterations, followed by one
// sign-fix cycle. Divide-by-zero and signed overflow finish at the accept edge.
//
// Optional build macro: MULDIV_OPCACHE_EN keeps the last full product (or
// quotient/remainder pair) with its operand tag, so a matching follow-up op
// (e.g. MULH after MUL, REM after DIV) completes at the accept edge.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   flush           synchronous abort, highest priority, returns to IDLE
//   in_valid/ready  request handshake (ready only in IDLE)
//   funct3          RV M-extension operation select
//   op_a, op_b      rs1 / rs2 values
//   out_valid/ready result handshake (valid only in DONE)
//   result          selected result, held stable in DONE
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        f3;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   bsrc;       // multiplicand / divisor magnitude
  logic [2*XLEN-1:0] prod;       // mul: {hi,lo} product; div: {rem, quotient/dividend}

  // ---------------- accept-time decode ----------------
  logic            is_div_in, sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
  logic [XLEN-1:0] abs_a_in, abs_b_in;
  logic            b_zero, ovf, special;
  logic [XLEN-1:0] spec_quo, spec_rem, spec_res;

  always_comb begin
    is_div_in = funct3[2];
    // a signed: MUL, MULH, MULHSU, DIV, REM; b signed: MUL, MULH, DIV, REM
    sgn_a_in  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b_in  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                (funct3 == 3'b100) || (funct3 == 3'b110);
    neg_a_in  = sgn_a_in & op_a[XLEN-1];
    neg_b_in  = sgn_b_in & op_b[XLEN-1];
    abs_a_in  = neg_a_in ? -op_a : op_a;
    abs_b_in  = neg_b_in ? -op_b : op_b;
    b_zero    = (op_b == '0);
    ovf       = is_div_in & sgn_b_in & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
    special   = is_div_in & (b_zero | ovf);
    spec_quo  = b_zero ? '1 : op_a;
    spec_rem  = b_zero ? op_a : '0;
    spec_res  = funct3[1] ? spec_rem : spec_quo;
  end

  // ---------------- iteration step ----------------
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] step_nxt;

  always_comb begin
    mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, bsrc} : '0);
    div_sh   = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    div_diff = div_sh - {1'b0, bsrc};
    if (f3[2]) begin
      // restoring: bit XLEN of the difference is the borrow
      if (div_diff[XLEN]) step_nxt = {div_sh[XLEN-1:0], prod[XLEN-2:0], 1'b0};
      else                step_nxt = {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
    end else begin
      step_nxt = {mul_sum, prod[XLEN-1:1]};
    end
  end

  // ---------------- sign fix and result select ----------------
  logic [2*XLEN-1:0] prod_s, fix_cache;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  always_comb begin
    prod_s = (neg_a ^ neg_b) ? -prod : prod;
    quo_s  = (neg_a ^ neg_b) ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    rem_s  = neg_a ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
    if (f3[2]) begin
      fix_res   = f3[1] ? rem_s : quo_s;
      fix_cache = {rem_s, quo_s};
    end else begin
      fix_res   = (f3 == 3'b000) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      fix_cache = prod_s;
    end
  end

  // ---------------- optional operand cache ----------------
  logic            hit;
  logic [XLEN-1:0] cache_sel;

`ifdef MULDIV_OPCACHE_EN
  logic              c_valid, c_sa, c_sb, c_div;
  logic [XLEN-1:0]   c_a, c_b;
  logic [2*XLEN-1:0] c_data;

  always_comb begin
    hit = c_valid && (c_a == op_a) && (c_b == op_b) && (c_sa == sgn_a_in) &&
          (c_sb == sgn_b_in) && (c_div == is_div_in);
    if (is_div_in) cache_sel = funct3[1] ? c_data[2*XLEN-1:XLEN] : c_data[XLEN-1:0];
    else           cache_sel = (funct3 == 3'b000) ? c_data[XLEN-1:0] : c_data[2*XLEN-1:XLEN];
  end

  // Tag is captured at accept with valid cleared; FIX fills data and sets valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid <= 1'b0;
      c_sa    <= 1'b0;
      c_sb    <= 1'b0;
      c_div   <= 1'b0;
      c_a     <= '0;
      c_b     <= '0;
      c_data  <= '0;
    end else if (flush) begin
      c_valid <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      if (special || !hit) begin
        c_a     <= op_a;
        c_b     <= op_b;
        c_sa    <= sgn_a_in;
        c_sb    <= sgn_b_in;
        c_div   <= is_div_in;
        c_valid <= special;
        if (special) c_data <= {spec_rem, spec_quo};
      end
    end else if (state == FIX) begin
      c_data  <= fix_cache;
      c_valid <= 1'b1;
    end
  end
`else
  always_comb begin
    hit       = 1'b0;
    cache_sel = '0;
  end
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE: if (in_valid) state_nxt = (special || hit) ? DONE : CALC;
      CALC: if (cnt == CW'(XLEN-1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      f3     <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      bsrc   <= '0;
      prod   <= '0;
      result <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (in_valid) begin
          f3    <= funct3;
          neg_a <= neg_a_in;
          neg_b <= neg_b_in;
          bsrc  <= abs_b_in;
          prod  <= {{XLEN{1'b0}}, abs_a_in};
          cnt   <= '0;
          if (special)  result <= spec_res;
          else if (hit) result <= cache_sel;
        end
        CALC: begin
          prod <= step_nxt;
          cnt  <= cnt + 1'b1;
        end
        FIX:  result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32): arithmetic results, latency,
// special cases, DONE hold, flush, mid-op reset and the optional cache.
module tb_muldiv_unit;
  localparam int XLEN = 32;
`ifdef MULDIV_OPCACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 34;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] op_a = '0, op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Latency = edges from the accept edge to the first edge that sees out_valid.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(result), 64'(exp));
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk({tag, "_ret_idle"}, {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  initial begin
    int bad, seen;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // multiply
    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("mulh",   3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 34);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);
    run_op("mulhu0", 3'b011, 32'd0,        32'd5,        32'd0,        34);
    // divide
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       34);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        34);
    run_op("divu_big", 3'b101, 32'hFFFFFFFF, 32'd16,     32'h0FFFFFFF, 34);
    // special cases
    run_op("divu_z", 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_z",  3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // DONE hold with out_ready low
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("calc_in_ready", 64'(in_ready), 64'd0);
    bad = 0;
    while (!out_valid && bad < 200) begin @(negedge clk); bad++; end
    chk("hold_res", 64'(result), 64'd15);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || result != 32'd15 || in_ready) bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;

    // flush after the 15th iteration
    @(negedge clk);
    funct3 = 3'b011; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_idle", {62'd0, in_ready, out_valid}, 64'b10);
    chk("flush_res_kept", 64'(result), 64'd15);
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1; end
    chk("flush_no_valid", 64'(seen), 64'd0);

    // flush coincident with an accept drops the request
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd9; op_b = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_accept_drop", {62'd0, in_ready, out_valid}, 64'b10);

    // reset mid-CALC
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1; end
    chk("midrst_no_valid", 64'(seen), 64'd0);

    // cache behaviour (hit latency depends on build)
    run_op("c_div",  3'b100, 32'd100, 32'd7, 32'd14, 34);
    run_op("c_rem",  3'b110, 32'd100, 32'd7, 32'd2,  HIT_LAT);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    run_op("c_rem_flushed", 3'b110, 32'd100, 32'd7, 32'd2, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
